exec_trace_buffer: RTL and testbench

- Synthesisable capture buffer for core execution events: register-file writebacks and data-memory writes, each tagged with hardware-thread index.
- Sits beside RISCV_core, tapping its debug outputs (regfile_wr_*, thread_index_wb, dmem write bus, thread_index_wrmem).
- Packs events into fixed-format records in a circular buffer accepting up to two pushes per cycle; drains through a valid/ready stream to a host or MMIO reader.
- Generalises simulation-only register/memory dump logic into parametrised hardware: configurable thread count, depth and address width, plus per-thread filtering and loss accounting.

---
 rtl/exec_trace_buffer.sv | 142 ++++++++++++++
 tb/tb_exec_trace_buffer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_trace_buffer.sv
// exec_trace_buffer: captures RF writebacks and dmem writes into a two-push circular buffer drained by valid/ready.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running timestamp per record; without it the ts field is 0.
module exec_trace_buffer #(
  parameter int NUM_THREADS = 16,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 14,
  parameter int TS_W        = 32,
  parameter int FILTER_X0   = 1,
  localparam int THREAD_W   = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int REC_W      = 1 + THREAD_W + 4 + ADDR_W + 32 + TS_W,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [NUM_THREADS-1:0] i_thread_mask,
  input  logic                   i_rf_wr_en,
  input  logic [4:0]             i_rf_wr_addr,
  input  logic [31:0]            i_rf_wr_data,
  input  logic [THREAD_W-1:0]    i_rf_thread,
  input  logic [3:0]             i_dmem_we,
  input  logic [ADDR_W-1:0]      i_dmem_addr,
  input  logic [31:0]            i_dmem_wdata,
  input  logic [THREAD_W-1:0]    i_dmem_thread,
  output logic                   o_trace_valid,
  input  logic                   i_trace_ready,
  output logic [REC_W-1:0]       o_trace_data,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_overflow,
  output logic [15:0]            o_drop_count,
  input  logic                   i_clear_stats
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TS_W-1:0] ts_value;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  always_ff @(posedge clk) begin
    if (reset) ts_reg <= '0;
    else       ts_reg <= ts_reg + TS_W'(1);
  end

  assign ts_value = ts_reg;
`else
  assign ts_value = '0;
`endif

  // Stage 1: qualify and register events together with their sample-edge timestamp.
  logic             x0_filtered;
  logic             rf_event;
  logic             mem_event;
  logic             rf_vld_reg;
  logic             mem_vld_reg;
  logic [REC_W-1:0] rf_rec_reg;
  logic [REC_W-1:0] mem_rec_reg;

  assign x0_filtered = (FILTER_X0 != 0) && (i_rf_wr_addr == 5'd0);
  assign rf_event    = i_enable & i_rf_wr_en & i_thread_mask[i_rf_thread] & ~x0_filtered;
  assign mem_event   = i_enable & (|i_dmem_we) & i_thread_mask[i_dmem_thread];

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_vld_reg  <= 1'b0;
      mem_vld_reg <= 1'b0;
    end else begin
      rf_vld_reg  <= rf_event;
      mem_vld_reg <= mem_event;
    end
    rf_rec_reg  <= {1'b0, i_rf_thread, 4'b1111, ADDR_W'(i_rf_wr_addr), i_rf_wr_data, ts_value};
    mem_rec_reg <= {1'b1, i_dmem_thread, i_dmem_we, i_dmem_addr, i_dmem_wdata, ts_value};
  end

  // Stage 2: space check uses occupancy before this cycle's pop, so a pop never frees a slot early.
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] free;
  logic [PTR_W-1:0] wptr_reg;
  logic [PTR_W-1:0] rptr_reg;
  logic [PTR_W-1:0] mem_wr_idx;
  logic             store_rf;
  logic             store_mem;
  logic             pop;
  logic [1:0]       n_push;
  logic [1:0]       n_drop;

  always_comb begin
    free       = CNT_W'(DEPTH) - count_reg;
    store_rf   = rf_vld_reg && (free != '0);
    store_mem  = mem_vld_reg && (free >= (rf_vld_reg ? CNT_W'(2) : CNT_W'(1)));
    n_push     = {1'b0, store_rf} + {1'b0, store_mem};
    n_drop     = {1'b0, rf_vld_reg & ~store_rf} + {1'b0, mem_vld_reg & ~store_mem};
    mem_wr_idx = store_rf ? wptr_reg + PTR_W'(1) : wptr_reg;
    pop        = o_trace_valid & i_trace_ready;
    count_next = count_reg + CNT_W'(n_push) - CNT_W'(pop);
  end

  logic [REC_W-1:0] trace_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (store_rf)  trace_mem[wptr_reg]   <= rf_rec_reg;
    if (store_mem) trace_mem[mem_wr_idx] <= mem_rec_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      wptr_reg  <= wptr_reg + PTR_W'(n_push);
      rptr_reg  <= rptr_reg + PTR_W'(pop);
      count_reg <= count_next;
    end
  end

  // Loss accounting: a clear in the same cycle as drops keeps only this cycle's drops.
  logic        overflow_reg;
  logic [15:0] drop_count_reg;
  logic [16:0] drop_sum;

  assign drop_sum = (i_clear_stats ? 17'd0 : {1'b0, drop_count_reg}) + 17'(n_drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      overflow_reg   <= (i_clear_stats ? 1'b0 : overflow_reg) | (n_drop != 2'd0);
      drop_count_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign o_trace_valid = (count_reg != '0);
  assign o_trace_data  = trace_mem[rptr_reg];
  assign o_count       = count_reg;
  assign o_overflow    = overflow_reg;
  assign o_drop_count  = drop_count_reg;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Self-checking bench for exec_trace_buffer: directed vector table, multi-cycle corner sequences, random vs queue model.
module tb_exec_trace_buffer;
  localparam int NUM_THREADS = 16;
  localparam int DEPTH       = 64;
  localparam int ADDR_W      = 14;
  localparam int TS_W        = 32;
  localparam int THREAD_W    = 4;
  localparam int REC_W       = 1 + THREAD_W + 4 + ADDR_W + 32 + TS_W;
  localparam int CNT_W       = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   i_enable;
  logic [NUM_THREADS-1:0] i_thread_mask;
  logic                   i_rf_wr_en;
  logic [4:0]             i_rf_wr_addr;
  logic [31:0]            i_rf_wr_data;
  logic [THREAD_W-1:0]    i_rf_thread;
  logic [3:0]             i_dmem_we;
  logic [ADDR_W-1:0]      i_dmem_addr;
  logic [31:0]            i_dmem_wdata;
  logic [THREAD_W-1:0]    i_dmem_thread;
  logic                   o_trace_valid;
  logic                   i_trace_ready;
  logic [REC_W-1:0]       o_trace_data;
  logic [CNT_W-1:0]       o_count;
  logic                   o_overflow;
  logic [15:0]            o_drop_count;
  logic                   i_clear_stats;

  exec_trace_buffer #(
    .NUM_THREADS(NUM_THREADS), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TS_W(TS_W), .FILTER_X0(1)
  ) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_thread_mask(i_thread_mask),
    .i_rf_wr_en(i_rf_wr_en), .i_rf_wr_addr(i_rf_wr_addr), .i_rf_wr_data(i_rf_wr_data),
    .i_rf_thread(i_rf_thread), .i_dmem_we(i_dmem_we), .i_dmem_addr(i_dmem_addr),
    .i_dmem_wdata(i_dmem_wdata), .i_dmem_thread(i_dmem_thread), .o_trace_valid(o_trace_valid),
    .i_trace_ready(i_trace_ready), .o_trace_data(o_trace_data), .o_count(o_count),
    .o_overflow(o_overflow), .o_drop_count(o_drop_count), .i_clear_stats(i_clear_stats)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of buffered records, list of captured-but-not-yet-written events.
  logic [REC_W-1:0] q[$];
  logic [REC_W-1:0] pend[$];
  logic             m_ovf;
  int               m_drops;
  logic [31:0]      m_ts;

  function automatic logic [REC_W-1:0] mk_rec(input logic kind, input logic [3:0] thr, input logic [3:0] be,
                                             input logic [13:0] addr, input logic [31:0] data, input logic [31:0] ts);
    return {kind, thr, be, addr, data, ts};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int free;
    int dropped;
    logic [31:0] cur_ts;
    if (reset) begin
      q.delete();
      pend.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_ts    = '0;
    end else begin
      free    = DEPTH - q.size();
      dropped = 0;
      if (i_trace_ready && q.size() != 0) void'(q.pop_front());
      foreach (pend[k]) begin
        if (free > 0) begin
          q.push_back(pend[k]);
          free--;
        end else begin
          dropped++;
        end
      end
      if (i_clear_stats) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (dropped > 0) m_ovf = 1'b1;
      m_drops = (m_drops + dropped > 65535) ? 65535 : m_drops + dropped;
      pend.delete();
`ifdef TRACE_TIMESTAMP_EN
      cur_ts = m_ts;
`else
      cur_ts = '0;
`endif
      if (i_enable && i_rf_wr_en && i_thread_mask[i_rf_thread] && i_rf_wr_addr != 5'd0)
        pend.push_back(mk_rec(1'b0, i_rf_thread, 4'hF, {9'd0, i_rf_wr_addr}, i_rf_wr_data, cur_ts));
      if (i_enable && i_dmem_we != 4'd0 && i_thread_mask[i_dmem_thread])
        pend.push_back(mk_rec(1'b1, i_dmem_thread, i_dmem_we, i_dmem_addr, i_dmem_wdata, cur_ts));
      m_ts = m_ts + 32'd1;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, " valid"}, o_trace_valid, q.size() != 0);
    check({tag, " count"}, o_count, q.size());
    check({tag, " overflow"}, o_overflow, m_ovf);
    check({tag, " drops"}, o_drop_count, m_drops);
    if (q.size() != 0) check({tag, " data"}, o_trace_data, q[0]);
  endtask

  task automatic idle();
    i_rf_wr_en = 1'b0;
    i_rf_wr_addr = '0;
    i_rf_wr_data = '0;
    i_rf_thread = '0;
    i_dmem_we = '0;
    i_dmem_addr = '0;
    i_dmem_wdata = '0;
    i_dmem_thread = '0;
  endtask

  task automatic rf_ev(input logic [4:0] a, input logic [31:0] d, input logic [3:0] t);
    i_rf_wr_en = 1'b1;
    i_rf_wr_addr = a;
    i_rf_wr_data = d;
    i_rf_thread = t;
  endtask

  task automatic mem_ev(input logic [3:0] we, input logic [13:0] a, input logic [31:0] d, input logic [3:0] t);
    i_dmem_we = we;
    i_dmem_addr = a;
    i_dmem_wdata = d;
    i_dmem_thread = t;
  endtask

  typedef struct {
    logic [15:0] mask;
    logic        rf_en;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [3:0]  rf_thr;
    logic [3:0]  we;
    logic [13:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  dthr;
    logic        ready;
    logic        exp_valid;
    int          exp_count;
    logic        exp_kind;
    logic [3:0]  exp_be;
    logic [13:0] exp_addr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{16'hFFFF, 1'b1, 5'd5, 32'hAA, 4'd3, 4'h0, 14'h0, 32'h0, 4'd0, 1'b0, 1'b0, 0, 1'b0, 4'h0, 14'h0};
    vecs[1]  = '{16'hFFFF, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b0, 1'b1, 1, 1'b0, 4'hF, 14'h5};
    vecs[2]  = '{16'hFFFF, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b1, 1'b0, 0, 1'b0, 4'h0, 14'h0};
    vecs[3]  = '{16'hFFFF, 1'b1, 5'd7, 32'h11, 4'd1, 4'h3, 14'h100, 32'h2222, 4'd2, 1'b0, 1'b0, 0, 1'b0, 4'h0, 14'h0};
    vecs[4]  = '{16'hFFFF, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b0, 1'b1, 2, 1'b0, 4'hF, 14'h7};
    vecs[5]  = '{16'hFFFF, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1, 1'b1, 4'h3, 14'h100};
    vecs[6]  = '{16'hFFFF, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b1, 1'b0, 0, 1'b0, 4'h0, 14'h0};
    vecs[7]  = '{16'hFFFE, 1'b1, 5'd3, 32'h33, 4'd0, 4'h1, 14'h20, 32'h44, 4'd4, 1'b0, 1'b0, 0, 1'b0, 4'h0, 14'h0};
    vecs[8]  = '{16'hFFFE, 1'b1, 5'd0, 32'h55, 4'd4, 4'hF, 14'h40, 32'h66, 4'd0, 1'b0, 1'b1, 1, 1'b1, 4'h1, 14'h20};
    vecs[9]  = '{16'hFFFE, 1'b1, 5'd9, 32'h77, 4'd4, 4'h0, 14'h0, 32'h0, 4'd0, 1'b0, 1'b1, 1, 1'b1, 4'h1, 14'h20};
    vecs[10] = '{16'hFFFE, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b0, 1'b1, 2, 1'b1, 4'h1, 14'h20};
    vecs[11] = '{16'hFFFE, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b1, 1'b1, 1, 1'b0, 4'hF, 14'h9};
    vecs[12] = '{16'hFFFE, 1'b0, 5'd0, 32'h0, 4'd0, 4'h0, 14'h0, 32'h0, 4'd0, 1'b1, 1'b0, 0, 1'b0, 4'h0, 14'h0};

    reset = 1'b1;
    i_enable = 1'b1;
    i_thread_mask = '1;
    i_trace_ready = 1'b0;
    i_clear_stats = 1'b0;
    idle();
    step("reset0");
    step("reset1");
    reset = 1'b0;

    foreach (vecs[i]) begin
      i_thread_mask = vecs[i].mask;
      i_rf_wr_en = vecs[i].rf_en;
      i_rf_wr_addr = vecs[i].rf_addr;
      i_rf_wr_data = vecs[i].rf_data;
      i_rf_thread = vecs[i].rf_thr;
      mem_ev(vecs[i].we, vecs[i].daddr, vecs[i].wdata, vecs[i].dthr);
      i_trace_ready = vecs[i].ready;
      step("vec");
      check("vec_valid", o_trace_valid, vecs[i].exp_valid);
      check("vec_count", o_count, vecs[i].exp_count);
      if (vecs[i].exp_valid) begin
        check("vec_kind", o_trace_data[REC_W-1], vecs[i].exp_kind);
        check("vec_be", o_trace_data[81:78], vecs[i].exp_be);
        check("vec_addr", o_trace_data[77:64], vecs[i].exp_addr);
      end
      $display("vec %0d: valid=%0b count=%0d drops=%0d", i, o_trace_valid, o_count, o_drop_count);
    end
    check("vec_drops", o_drop_count, 16'd0);
    i_thread_mask = '1;
    idle();

    // Fill past capacity with one event per cycle.
    i_trace_ready = 1'b0;
    for (int i = 0; i < 66; i++) begin
      rf_ev(5'((i % 31) + 1), 32'(i), 4'(i % 16));
      step("fill");
    end
    idle();
    step("fill_tail");
    step("fill_tail");
    check("full_count", o_count, 7'd64);
    check("full_overflow", o_overflow, 1'b1);
    check("full_drops", o_drop_count, 16'd2);
    $display("fill: count=%0d overflow=%0b drops=%0d", o_count, o_overflow, o_drop_count);

    i_trace_ready = 1'b1;
    step("pop_one");
    check("pop_one_count", o_count, 7'd63);
    i_trace_ready = 1'b0;
    rf_ev(5'd12, 32'hC0DE, 4'd2);
    mem_ev(4'hF, 14'h3FF, 32'hBEEF, 4'd6);
    step("pair_sample");
    idle();
    step("pair_write");
    check("pair_count", o_count, 7'd64);
    check("pair_drops", o_drop_count, 16'd3);
    $display("pair into one slot: count=%0d drops=%0d", o_count, o_drop_count);

    // Full with pop in the write cycle: the pop does not make room for that cycle's event.
    rf_ev(5'd1, 32'h1, 4'd1);
    step("fullpop_a");
    rf_ev(5'd2, 32'h2, 4'd1);
    i_trace_ready = 1'b1;
    step("fullpop_b");
    check("fullpop_count", o_count, 7'd63);
    check("fullpop_drops", o_drop_count, 16'd4);
    idle();
    i_trace_ready = 1'b0;
    step("fullpop_c");
    check("refill_count", o_count, 7'd64);
    check("refill_drops", o_drop_count, 16'd4);
    $display("full+pop: count=%0d drops=%0d", o_count, o_drop_count);

    i_clear_stats = 1'b1;
    step("clear");
    check("clear_overflow", o_overflow, 1'b0);
    check("clear_drops", o_drop_count, 16'd0);
    i_clear_stats = 1'b0;
    rf_ev(5'd3, 32'h3, 4'd0);
    step("clear_drop_a");
    idle();
    i_clear_stats = 1'b1;
    step("clear_drop_b");
    check("clear_drop_overflow", o_overflow, 1'b1);
    check("clear_drop_drops", o_drop_count, 16'd1);
    i_clear_stats = 1'b0;
    $display("clear with drop: overflow=%0b drops=%0d", o_overflow, o_drop_count);

    // Saturation: two drops per cycle on a full buffer.
    rf_ev(5'd4, 32'h4, 4'd5);
    mem_ev(4'h8, 14'h10, 32'h5, 4'd5);
    for (int i = 0; i < 32768; i++) step("sat");
    idle();
    step("sat_tail");
    check("sat_drops", o_drop_count, 16'hFFFF);
    $display("saturate: drops=%0h", o_drop_count);

    // Reset with entries buffered.
    reset = 1'b1;
    step("rst_a");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rf_ev(5'(i + 1), 32'(i * 3), 4'(i));
      step("ten");
    end
    idle();
    step("ten_tail");
    check("ten_count", o_count, 7'd10);
    reset = 1'b1;
    step("rst_b");
    check("rst_valid", o_trace_valid, 1'b0);
    check("rst_count", o_count, 7'd0);
    check("rst_overflow", o_overflow, 1'b0);
    reset = 1'b0;
    $display("mid reset: valid=%0b count=%0d", o_trace_valid, o_count);

    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      i_enable = ($urandom_range(0, 15) != 0);
      i_thread_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      i_rf_wr_en = 1'($urandom_range(0, 1));
      i_rf_wr_addr = 5'($urandom_range(0, 31));
      i_rf_wr_data = $urandom;
      i_rf_thread = 4'($urandom);
      i_dmem_we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      i_dmem_addr = 14'($urandom);
      i_dmem_wdata = $urandom;
      i_dmem_thread = 4'($urandom);
      i_trace_ready = ($urandom_range(0, 99) < (((n / 500) % 2 != 0) ? 30 : 85));
      i_clear_stats = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
